// File: rtl/bif_lbus_pkg.sv
// Shared types and widths for the local-bus address-phase sequencer.
package bif_lbus_pkg;

    localparam int unsigned PPN_W = 14;
    localparam int unsigned CA_W  = 10;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StStrb,
        StAddr,
        StWait
    } lbus_state_e;

    // Down-counter load value for a phase lasting 'cycles' sysclk cycles.
    function automatic logic [CNT_W-1:0] cnt_load_val(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/bif_lbus_addr_seq_if.sv
// Request-side and local-bus signals of the address-phase sequencer.
interface bif_lbus_addr_seq_if;
    import bif_lbus_pkg::*;

    logic             req;
    logic [PPN_W-1:0] req_ppn;
    logic [CA_W-1:0]  req_ca;
    logic             req_wr;
    logic             lb_grant;
    logic             lb_ack;
    logic             req_ack;
    logic             lb_req;
    logic [PPN_W-1:0] ppn_23_10;
    logic [CA_W-1:0]  ca_9_0;
    logic             ecreq;
    logic             eadr_n;
    logic             lb_wr;
    logic             busy;
    logic             done;
    logic             tmo_err;

    modport master (
        output req, req_ppn, req_ca, req_wr, lb_grant, lb_ack,
        input  req_ack, lb_req, ppn_23_10, ca_9_0, ecreq, eadr_n, lb_wr, busy, done, tmo_err
    );

    modport slave (
        input  req, req_ppn, req_ca, req_wr, lb_grant, lb_ack,
        output req_ack, lb_req, ppn_23_10, ca_9_0, ecreq, eadr_n, lb_wr, busy, done, tmo_err
    );

endinterface

// File: rtl/bif_lbus_tmo_cnt.sv
// Loadable/clearable down-counter; tc flags a zero count.
module bif_lbus_tmo_cnt
    import bif_lbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/bif_lbus_addr_seq.sv
// Local-bus address-phase sequencer: captures a request, arbitrates, strobes the
// address latch, drives the EADR_n window and waits for ack or timeout.
module bif_lbus_addr_seq
    import bif_lbus_pkg::*;
#(
    parameter int unsigned ADDR_CYCLES = 2,
    parameter int unsigned TMO_CYCLES  = 255
) (
    input logic                sysclk,
    input logic                sys_rst,
    bif_lbus_addr_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] AddrLoad = cnt_load_val(ADDR_CYCLES);
    localparam logic [CNT_W-1:0] TmoLoad  = cnt_load_val(TMO_CYCLES);

    lbus_state_e      state_q;
    logic             req_ack_q;
    logic             lb_req_q;
    logic [PPN_W-1:0] ppn_q;
    logic [CA_W-1:0]  ca_q;
    logic             ecreq_q;
    logic             eadr_n_q;
    logic             lb_wr_q;
    logic             busy_q;
    logic             done_q;
    logic             tmo_err_q;

    logic             cnt_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val_w;
    logic             cnt_dec;
    logic             cnt_tc;

    bif_lbus_tmo_cnt u_cnt (
        .clk      (sysclk),
        .rst      (sys_rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val_w),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // One counter serves both phases: ADDR window length, then ack timeout.
    always_comb begin
        cnt_clr        = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_val_w = AddrLoad;
        cnt_dec        = 1'b0;
        unique case (state_q)
            StStrb: cnt_load = ecreq_q;
            StAddr: begin
                if (cnt_tc) begin
                    cnt_load       = 1'b1;
                    cnt_load_val_w = TmoLoad;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWait: begin
                if (bus.lb_ack || cnt_tc) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            req_ack_q <= 1'b0;
            lb_req_q  <= 1'b0;
            ppn_q     <= '0;
            ca_q      <= '0;
            ecreq_q   <= 1'b0;
            eadr_n_q  <= 1'b1;
            lb_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            req_ack_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        state_q   <= StArb;
                        req_ack_q <= 1'b1;
                        lb_req_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        ppn_q     <= bus.req_ppn;
                        ca_q      <= bus.req_ca;
                        lb_wr_q   <= bus.req_wr;
                    end
                end
                StArb: begin
                    if (bus.lb_grant) begin
                        state_q <= StStrb;
                    end
                end
                // First STRB cycle is latch setup; ecreq rises on the second.
                StStrb: begin
                    if (!ecreq_q) begin
                        ecreq_q <= 1'b1;
                    end else begin
                        ecreq_q  <= 1'b0;
                        eadr_n_q <= 1'b0;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    if (cnt_tc) begin
                        eadr_n_q <= 1'b1;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (bus.lb_ack) begin
                        done_q   <= 1'b1;
                        lb_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else if (cnt_tc) begin
                        tmo_err_q <= 1'b1;
                        lb_req_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.lb_req    = lb_req_q;
    assign bus.ppn_23_10 = ppn_q;
    assign bus.ca_9_0    = ca_q;
    assign bus.ecreq     = ecreq_q;
    assign bus.eadr_n    = eadr_n_q;
    assign bus.lb_wr     = lb_wr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_bif_lbus_addr_seq.sv
// Bench for bif_lbus_addr_seq: per-transaction timeline predicted from the
// cycle rules (accept, grant, strobe, address window, ack/timeout).
module tb_bif_lbus_addr_seq;

    localparam int AC  = 2;
    localparam int TMO = 4;

    logic sysclk  = 1'b0;
    logic sys_rst = 1'b1;

    bif_lbus_addr_seq_if bus ();

    bif_lbus_addr_seq #(
        .ADDR_CYCLES (AC),
        .TMO_CYCLES  (TMO)
    ) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int txn_id = 0;

    logic [13:0] exp_ppn = '0;
    logic [9:0]  exp_ca  = '0;
    logic        exp_wr  = 1'b0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int k, input logic e_ack, input logic e_lbreq,
                                 input logic e_ecreq, input logic e_eadr_n, input logic e_busy,
                                 input logic e_done, input logic e_tmo);
        string t;
        t = $sformatf("t%0d.k%0d", txn_id, k);
        chk_bit({t, " req_ack"}, bus.req_ack, e_ack);
        chk_bit({t, " lb_req"},  bus.lb_req,  e_lbreq);
        chk_bit({t, " ecreq"},   bus.ecreq,   e_ecreq);
        chk_bit({t, " eadr_n"},  bus.eadr_n,  e_eadr_n);
        chk_bit({t, " busy"},    bus.busy,    e_busy);
        chk_bit({t, " done"},    bus.done,    e_done);
        chk_bit({t, " tmo_err"}, bus.tmo_err, e_tmo);
        chk_bit({t, " lb_wr"},   bus.lb_wr,   exp_wr);
        chk_vec({t, " ppn"},     16'(bus.ppn_23_10), 16'(exp_ppn));
        chk_vec({t, " ca"},      16'(bus.ca_9_0),    16'(exp_ca));
    endtask

    task automatic idle_cycles(input int n);
        txn_id++;
        for (int i = 0; i < n; i++) begin
            bus.req      = 1'b0;
            bus.req_ppn  = 14'($urandom);
            bus.req_ca   = 10'($urandom);
            bus.req_wr   = 1'($urandom);
            bus.lb_grant = 1'($urandom);
            bus.lb_ack   = 1'($urandom);
            @(posedge sysclk);
            #1;
            check_outputs(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // k counts edges from acceptance (k=0). gd: ARB edges with grant low.
    // ad: WAIT edge (1-based) at which ack is first sampled; ad > TMO means timeout.
    task automatic run_txn(input int gd, input int ad, input bit early_ack, input bit hold_req,
                           input logic [13:0] ppn, input logic [9:0] ca, input logic wr,
                           input int rst_at);
        int  s, w, e;
        bit  ok_done;
        txn_id++;
        if (early_ack) ad = 1;
        s       = 1 + gd;
        w       = s + 2 + AC;
        ok_done = (ad <= TMO);
        e       = w + (ok_done ? ad : TMO);
        for (int k = 0; k <= e; k++) begin
            if (k == 0) begin
                bus.req     = 1'b1;
                bus.req_ppn = ppn;
                bus.req_ca  = ca;
                bus.req_wr  = wr;
            end else begin
                bus.req     = hold_req ? 1'b1 : 1'($urandom);
                bus.req_ppn = 14'($urandom);
                bus.req_ca  = 10'($urandom);
                bus.req_wr  = 1'($urandom);
            end
            if (k == 0)      bus.lb_grant = 1'($urandom);
            else if (k < s)  bus.lb_grant = 1'b0;
            else if (k == s) bus.lb_grant = 1'b1;
            else             bus.lb_grant = 1'($urandom);
            if (k <= w)      bus.lb_ack = (early_ack && k > s) ? 1'b1 : 1'($urandom);
            else             bus.lb_ack = ok_done && (k >= w + ad);
            @(posedge sysclk);
            #1;
            if (k == 0) begin
                exp_ppn = ppn;
                exp_ca  = ca;
                exp_wr  = wr;
            end
            check_outputs(k, k == 0, k < e, k == s + 1, !(k >= s + 2 && k < s + 2 + AC), k < e,
                          (k == e) && ok_done, (k == e) && !ok_done);
            if (k == rst_at) begin
                #2;
                sys_rst = 1'b1;
                #1;
                exp_ppn = '0;
                exp_ca  = '0;
                exp_wr  = 1'b0;
                check_outputs(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                @(posedge sysclk);
                #3;
                sys_rst = 1'b0;
                return;
            end
        end
        bus.req    = hold_req;
        bus.lb_ack = 1'b0;
    endtask

    initial begin
        bus.req      = 1'b0;
        bus.req_ppn  = '0;
        bus.req_ca   = '0;
        bus.req_wr   = 1'b0;
        bus.lb_grant = 1'b0;
        bus.lb_ack   = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check_outputs(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge sysclk);
        #1;
        sys_rst = 1'b0;
        idle_cycles(2);

        // Basic cycle, grant already high, ack two WAIT edges in.
        run_txn(0, 2, 1'b0, 1'b0, 14'h2A5B, 10'h3C1, 1'b1, -1);
        idle_cycles(2);
        // Grant delayed five cycles.
        run_txn(5, 1, 1'b0, 1'b0, 14'h1234, 10'h0AA, 1'b0, -1);
        idle_cycles(1);
        // No ack: timeout.
        run_txn(0, TMO + 1, 1'b0, 1'b0, 14'h3FFF, 10'h3FF, 1'b1, -1);
        idle_cycles(1);
        // Ack coincident with the timeout limit, then early ack held through ADDR.
        run_txn(1, TMO, 1'b0, 1'b0, 14'h0001, 10'h200, 1'b0, -1);
        idle_cycles(1);
        run_txn(0, 1, 1'b1, 1'b0, 14'h2000, 10'h001, 1'b1, -1);
        idle_cycles(1);
        // Back-to-back with req held throughout.
        run_txn(2, 3, 1'b0, 1'b1, 14'h0F0F, 10'h155, 1'b1, -1);
        run_txn(0, 2, 1'b0, 1'b1, 14'h30C3, 10'h2AA, 1'b0, -1);
        run_txn(1, TMO + 1, 1'b0, 1'b0, 14'h1111, 10'h0F0, 1'b1, -1);
        idle_cycles(2);

        for (int t = 0; t < 14; t++) begin
            int gd;
            int ad;
            bit early;
            bit hold;
            gd    = int'($urandom_range(0, 4));
            ad    = int'($urandom_range(1, TMO + 1));
            early = ($urandom_range(0, 3) == 0);
            hold  = 1'($urandom);
            run_txn(gd, ad, early, hold, 14'($urandom), 10'($urandom), 1'($urandom), -1);
            if (!hold) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(1);

        // Asynchronous reset in the first ADDR cycle (grant at edge 1, ADDR from edge 3).
        run_txn(0, 1, 1'b0, 1'b0, 14'h2BCD, 10'h1EF, 1'b1, 3);
        idle_cycles(TMO + AC + 4);
        run_txn(0, 1, 1'b0, 1'b0, 14'h0ABC, 10'h123, 1'b0, -1);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
